// File: rtl/pipe_ctrl_n.sv
// Pipeline control: per-stage stall freeze vector, exception/ertn flush-redirect
// sequencer with vectored handler addressing, and a saturating stall-cycle counter.
module pipe_ctrl_n #(
   parameter int NUM_STAGES   = 7,
   parameter int ADDR_W       = 32,
   parameter int CAUSE_W      = 6,
   parameter int VECTORED     = 0,
   parameter int VEC_SHIFT    = 6,
   parameter int FLUSH_CYCLES = 1,
   parameter int CNT_W        = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NUM_STAGES-1:0] stallreq,
   input  logic                  except_valid,
   input  logic [CAUSE_W-1:0]    except_cause,
   input  logic [ADDR_W-1:0]     eentry_base,
   input  logic                  ertn_valid,
   input  logic [ADDR_W-1:0]     ertn_pc,
   input  logic                  redirect_ready,
   output logic [NUM_STAGES-1:0] stall,
   output logic                  flush,
   output logic                  redirect_valid,
   output logic [ADDR_W-1:0]     new_pc,
   output logic                  busy,
   output logic [CNT_W-1:0]      stall_cycles
);

   typedef enum logic [1:0] {RUN, FLUSH, REDIR} state_t;

   localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

   state_t                  state_q, state_d;
   logic [FCW-1:0]          fcnt_q, fcnt_d;
   logic [ADDR_W-1:0]       new_pc_q, new_pc_d;
   logic [ADDR_W-1:0]       vec_off, target;
   logic [NUM_STAGES-1:0]   stall_mask;
   logic [CNT_W-1:0]        cnt_q;

   // A stalled stage must also freeze everything upstream of it.
   always_comb begin : stall_scan
      logic acc;
      acc = 1'b0;
      stall_mask = '0;
      for (int k = NUM_STAGES - 1; k >= 0; k--) begin
         acc           = acc | stallreq[k];
         stall_mask[k] = acc;
      end
   end

   assign stall = (rst_n && state_q == RUN) ? stall_mask : '0;

   assign vec_off = ADDR_W'(except_cause) << VEC_SHIFT;

   // Exception outranks a same-cycle ertn.
   always_comb begin
      target = ertn_pc;
      if (except_valid)
         target = (VECTORED != 0) ? eentry_base + vec_off : eentry_base;
   end

   always_comb begin
      state_d  = state_q;
      fcnt_d   = fcnt_q;
      new_pc_d = new_pc_q;
      case (state_q)
         RUN: begin
            if (except_valid || ertn_valid) begin
               state_d  = FLUSH;
               fcnt_d   = FCW'(FLUSH_CYCLES - 1);
               new_pc_d = target;
            end
         end
         FLUSH: begin
            if (fcnt_q == '0) state_d = REDIR;
            else              fcnt_d  = fcnt_q - 1'b1;
         end
         REDIR: begin
            if (redirect_ready) state_d = RUN;
         end
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= RUN;
         fcnt_q   <= '0;
         new_pc_q <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         fcnt_q   <= fcnt_d;
         new_pc_q <= new_pc_d;
         if (|stall && cnt_q != '1)
            cnt_q <= cnt_q + 1'b1;
      end
   end

   assign flush          = (state_q == FLUSH);
   assign redirect_valid = (state_q == REDIR);
   assign busy           = (state_q != RUN);
   assign new_pc         = new_pc_q;
   assign stall_cycles   = cnt_q;

endmodule

// File: tb/tb_pipe_ctrl_n.sv
// Bench for pipe_ctrl_n: a vectored/2-cycle-flush/4-bit-counter instance and a
// non-vectored/1-cycle-flush instance share stimulus; redirects go through a scoreboard.
module tb_pipe_ctrl_n;
   localparam int NS = 7, AW = 32, CW = 6;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [NS-1:0] stallreq = '0;
   logic          except_valid = 1'b0, ertn_valid = 1'b0, redirect_ready = 1'b0;
   logic [CW-1:0] except_cause = '0;
   logic [AW-1:0] eentry_base = '0, ertn_pc = '0;

   logic [NS-1:0] stall_a, stall_b;
   logic          flush_a, flush_b, rv_a, rv_b, busy_a, busy_b;
   logic [AW-1:0] new_pc_a, new_pc_b;
   logic [3:0]    sc_a;
   logic [31:0]   sc_b;

   pipe_ctrl_n #(.NUM_STAGES(NS), .ADDR_W(AW), .CAUSE_W(CW), .VECTORED(1), .VEC_SHIFT(6),
                 .FLUSH_CYCLES(2), .CNT_W(4)) u_a (
      .clk(clk), .rst_n(rst_n), .stallreq(stallreq), .except_valid(except_valid),
      .except_cause(except_cause), .eentry_base(eentry_base), .ertn_valid(ertn_valid),
      .ertn_pc(ertn_pc), .redirect_ready(redirect_ready), .stall(stall_a), .flush(flush_a),
      .redirect_valid(rv_a), .new_pc(new_pc_a), .busy(busy_a), .stall_cycles(sc_a));

   pipe_ctrl_n #(.NUM_STAGES(NS), .ADDR_W(AW), .CAUSE_W(CW), .VECTORED(0), .VEC_SHIFT(6),
                 .FLUSH_CYCLES(1), .CNT_W(32)) u_b (
      .clk(clk), .rst_n(rst_n), .stallreq(stallreq), .except_valid(except_valid),
      .except_cause(except_cause), .eentry_base(eentry_base), .ertn_valid(ertn_valid),
      .ertn_pc(ertn_pc), .redirect_ready(redirect_ready), .stall(stall_b), .flush(flush_b),
      .redirect_valid(rv_b), .new_pc(new_pc_b), .busy(busy_b), .stall_cycles(sc_b));

   int checks = 0, errors = 0, exp_cnt = 0;
   logic [AW-1:0] sb_a[$], sb_b[$];

   typedef struct { logic [NS-1:0] req; logic [NS-1:0] exp; } stall_vec_t;
   stall_vec_t tbl[6];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [AW-1:0] model_tgt(input bit vec, input bit exc,
         input logic [CW-1:0] c, input logic [AW-1:0] base, input logic [AW-1:0] pc);
      logic [AW-1:0] off;
      off = {26'b0, c};
      if (!exc) return pc;
      if (!vec) return base;
      return base + (off << 6);
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_cnt;
      chk("cnt_a", sc_a, (exp_cnt > 15) ? 15 : exp_cnt);
      chk("cnt_b", sc_b, exp_cnt);
   endtask

   // Handshake monitor: each accepted redirect must match the oldest expectation.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && redirect_ready === 1'b1) begin
         if (rv_a === 1'b1) begin
            if (sb_a.size() == 0) chk("sb_a_underflow", 1, 0);
            else chk("redir_a", new_pc_a, sb_a.pop_front());
         end
         if (rv_b === 1'b1) begin
            if (sb_b.size() == 0) chk("sb_b_underflow", 1, 0);
            else chk("redir_b", new_pc_b, sb_b.pop_front());
         end
      end
   end

   task automatic run_event(input bit exc, input bit ertn, input logic [CW-1:0] c,
         input logic [AW-1:0] base, input logic [AW-1:0] pc, input string tag);
      int fa, fb;
      logic [AW-1:0] ea, eb;
      ea = model_tgt(1'b1, exc, c, base, pc);
      eb = model_tgt(1'b0, exc, c, base, pc);
      except_valid = exc; ertn_valid = ertn; except_cause = c;
      eentry_base = base; ertn_pc = pc;
      sb_a.push_back(ea);
      sb_b.push_back(eb);
      tick;
      except_valid = 1'b0; ertn_valid = 1'b0; redirect_ready = 1'b1;
      fa = 0; fb = 0;
      for (int i = 0; i < 20; i++) begin
         if (flush_a) fa++;
         if (flush_b) fb++;
         if (!busy_a && !busy_b) break;
         tick;
      end
      redirect_ready = 1'b0;
      chk({tag, "_flushes_a"}, fa, 2);
      chk({tag, "_flushes_b"}, fb, 1);
      chk({tag, "_idle_a"}, busy_a, 0);
      chk({tag, "_idle_b"}, busy_b, 0);
      chk({tag, "_pc_a"}, new_pc_a, ea);
      chk({tag, "_pc_b"}, new_pc_b, eb);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = '{7'b0000101, 7'b0000111};
      tbl[1] = '{7'b0100000, 7'b0111111};
      tbl[2] = '{7'b0000000, 7'b0000000};
      tbl[3] = '{7'b1000000, 7'b1111111};
      tbl[4] = '{7'b0000001, 7'b0000001};
      tbl[5] = '{7'b0010010, 7'b0011111};

      // Reset: stall forced low even with every request raised.
      rst_n = 1'b0; stallreq = '1;
      #1;
      chk("rst_stall_a", stall_a, 0);
      chk("rst_stall_b", stall_b, 0);
      tick; tick;
      chk("rst_flush", flush_a, 0);
      chk("rst_rv", rv_a, 0);
      chk("rst_busy", busy_a, 0);
      chk("rst_pc", new_pc_a, 0);
      chk_cnt;
      stallreq = '0; rst_n = 1'b1;
      tick;

      for (int i = 0; i < 6; i++) begin
         stallreq = tbl[i].req;
         #1;
         chk($sformatf("stall_a[%0d]", i), stall_a, tbl[i].exp);
         chk($sformatf("stall_b[%0d]", i), stall_b, tbl[i].exp);
         tick;
         if (tbl[i].exp != 0) exp_cnt++;
         chk_cnt;
      end
      stallreq = '0;

      // Vectored exception with stalled fetch; a second exception and full stall requests land mid-sequence.
      eentry_base = 32'h1C008000; except_cause = 6'h0B; except_valid = 1'b1;
      sb_a.push_back(32'h1C0082C0);
      sb_b.push_back(32'h1C008000);
      #1;
      chk("exc_t0_busy", busy_a, 0);
      tick;
      except_cause = 6'h3F; stallreq = '1;
      #1;
      chk("exc_t1_flush_a", flush_a, 1);
      chk("exc_t1_busy_a", busy_a, 1);
      chk("exc_t1_rv_a", rv_a, 0);
      chk("exc_t1_flush_b", flush_b, 1);
      chk("exc_t1_stall_a", stall_a, 0);
      tick;
      except_valid = 1'b0;
      chk("exc_t2_flush_a", flush_a, 1);
      chk("exc_t2_rv_a", rv_a, 0);
      chk("exc_t2_flush_b", flush_b, 0);
      chk("exc_t2_rv_b", rv_b, 1);
      chk("exc_t2_pc_b", new_pc_b, 32'h1C008000);
      chk("exc_t2_stall_b", stall_b, 0);
      tick;
      chk("exc_t3_flush_a", flush_a, 0);
      chk("exc_t3_rv_a", rv_a, 1);
      for (int i = 0; i < 3; i++) begin
         chk("hold_rv_a", rv_a, 1);
         chk("hold_pc_a", new_pc_a, 32'h1C0082C0);
         chk("hold_busy_a", busy_a, 1);
         chk("hold_stall_a", stall_a, 0);
         tick;
      end
      stallreq = '0; redirect_ready = 1'b1;
      #1;
      chk("pre_accept_rv_a", rv_a, 1);
      tick;
      redirect_ready = 1'b0;
      chk("accept_busy_a", busy_a, 0);
      chk("accept_rv_a", rv_a, 0);
      chk("accept_pc_a", new_pc_a, 32'h1C0082C0);
      chk("accept_busy_b", busy_b, 0);
      chk_cnt;
      tick;
      chk("no_extra_flush_a", flush_a, 0);
      chk("no_extra_flush_b", flush_b, 0);

      run_event(1'b1, 1'b1, 6'h05, 32'h1C008000, 32'h1C000100, "both");
      run_event(1'b0, 1'b1, 6'h05, 32'h1C008000, 32'h80001234, "ertn");
      run_event(1'b1, 1'b0, 6'h01, 32'hFFFFFFC0, 32'h0, "wrap");
      chk_cnt;

      stallreq = 7'b0000001;
      for (int i = 0; i < 20; i++) begin
         tick;
         exp_cnt++;
      end
      stallreq = '0;
      chk_cnt;

      // Reset while both instances sit in REDIR with the fetch unit stalled.
      except_valid = 1'b1; except_cause = 6'h02; eentry_base = 32'h00400000;
      sb_a.push_back(model_tgt(1'b1, 1'b1, 6'h02, 32'h00400000, 32'h0));
      sb_b.push_back(model_tgt(1'b0, 1'b1, 6'h02, 32'h00400000, 32'h0));
      tick;
      except_valid = 1'b0;
      tick; tick;
      chk("mid_rv_a", rv_a, 1);
      rst_n = 1'b0;
      tick;
      rst_n = 1'b1;
      sb_a.delete(); sb_b.delete();
      exp_cnt = 0;
      chk("mrst_rv_a", rv_a, 0);
      chk("mrst_flush_a", flush_a, 0);
      chk("mrst_busy_a", busy_a, 0);
      chk("mrst_pc_a", new_pc_a, 0);
      chk("mrst_busy_b", busy_b, 0);
      chk("mrst_pc_b", new_pc_b, 0);
      chk_cnt;

      stallreq = 7'b0000010;
      #1;
      chk("post_rst_stall", stall_a, 7'b0000011);
      tick;
      exp_cnt++;
      stallreq = '0;
      chk_cnt;

      chk("sb_empty", sb_a.size() + sb_b.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/pipe_ctrl_n.md
Name: pipe_ctrl_n

Overview:
Parametrised pipeline control unit for the N-stage in-order core. Converts per-stage stall requests into a stage-freeze vector. Sequences exception entry and exception return (ertn) through a registered flush/redirect state machine. Computes vectored or non-vectored handler addresses and counts stall cycles for performance monitoring.

Parameters:
NUM_STAGES, 7, number of pipeline stages controlled; stage 0 = PC/IF, stage NUM_STAGES-1 = writeback
ADDR_W, 32, PC/address width
CAUSE_W, 6, exception cause code width
VECTORED, 0, 1 = handler target is eentry_base + (cause << VEC_SHIFT); 0 = eentry_base
VEC_SHIFT, 6, byte shift per vector entry
FLUSH_CYCLES, 1, cycles flush is held asserted (>=1)
CNT_W, 32, stall cycle counter width

Ports:
clk  in  1  clock
rst_n  in  1  reset
stallreq  in  NUM_STAGES  bit k = stage k requests stall
except_valid  in  1  exception committed (single-cycle pulse)
except_cause  in  CAUSE_W  cause code, valid with except_valid
eentry_base  in  ADDR_W  handler base address
ertn_valid  in  1  exception return committed (pulse)
ertn_pc  in  ADDR_W  return address, valid with ertn_valid
redirect_ready  in  1  fetch unit accepts redirect
stall  out  NUM_STAGES  bit k = 1 freezes stage k
flush  out  1  kill all in-flight stages
redirect_valid  out  1  new_pc valid
new_pc  out  ADDR_W  redirect target
busy  out  1  FSM not in RUN
stall_cycles  out  CNT_W  saturating count of stalled cycles

Behaviour:
- Reset: rst_n, synchronous, active-low. When low at a clock edge: FSM->RUN, flush=0, redirect_valid=0, new_pc=0, stall_cycles=0, internal flush counter=0. stall is combinational and forced to 0 while rst_n=0.
- Stall vector (combinational, RUN only):
  - Let h = highest k with stallreq[k]=1. Then stall[h:0]=all ones and stall[NUM_STAGES-1:h+1]=0; downstream stages drain.
  - No request -> stall=0.
  - In FLUSH or REDIR, stall=0 regardless of stallreq.
- Target computation in RUN:
  - except_valid=1: target = VECTORED ? eentry_base + ({cause,VEC_SHIFT zeros} zero-extended to ADDR_W) : eentry_base. Addition is mod 2^ADDR_W (wraps).
  - ertn_valid=1 (no exception): target = ertn_pc.
  - Both in the same cycle: exception wins and ertn is dropped.
- FSM states RUN, FLUSH, REDIR:
  - RUN -> FLUSH on except_valid|ertn_valid. target is latched into new_pc at that edge, flush counter loads FLUSH_CYCLES-1. flush is registered: it asserts in the cycle after the event.
  - FLUSH: flush=1, busy=1. Counter decrements each cycle. When counter==0, go to REDIR at the next edge with flush=0 and redirect_valid=1. Exactly FLUSH_CYCLES cycles of flush.
  - REDIR: redirect_valid=1 and new_pc held stable until redirect_valid&redirect_ready at a clock edge. Then -> RUN, redirect_valid=0; new_pc keeps its last value.
  - except_valid/ertn_valid arriving in FLUSH or REDIR are ignored; they come from killed instructions.
- busy = (state != RUN), registered-state derived.
- stall_cycles: increments on each edge where stall != 0 while in RUN. Saturates at all-ones (no wrap).
- Latency: exception pulse to first flush cycle = 1. Pulse to redirect_valid = 1 + FLUSH_CYCLES.
- Reset mid-operation (FLUSH or REDIR) returns to RUN immediately; the pending redirect is discarded.

Test Plan:
- Stall priority (NUM_STAGES=7): stallreq=7'b0000101 -> stall=7'b0000111; stallreq=7'b0100000 -> stall=7'b0111111; stallreq=0 -> stall=0; stall_cycles +2 over those cycles.
- Exception, VECTORED=1, VEC_SHIFT=6, eentry_base=0x1C008000, cause=0x0B: flush=1 in cycle t+1 for FLUSH_CYCLES=2 (t+1,t+2), redirect_valid at t+3 with new_pc=0x1C0082C0; redirect_ready held 0 for 3 cycles -> new_pc stable, busy=1; ready=1 -> RUN next cycle.
- Simultaneous except_valid and ertn_valid (ertn_pc=0x1C000100, VECTORED=0, base=0x1C008000) -> new_pc=0x1C008000, single flush sequence.
- Event ignore/stall mask: second except_valid during FLUSH and stallreq=all ones during REDIR -> no extra flush, stall=0, new_pc unchanged, stall_cycles unchanged.
- Wrap/saturation: base=0xFFFFFFC0, cause=1, VEC_SHIFT=6 -> new_pc=0x00000000. CNT_W=4 with 20 stalled cycles -> stall_cycles=4'hF.
- Reset mid-REDIR: rst_n=0 for one edge -> redirect_valid=0, flush=0, busy=0, stall_cycles=0, new_pc=0 next cycle.
